// File: rtl/hs_mem_bank.sv
// ============================================================================
// hs_mem_bank
// ----------------------------------------------------------------------------
// Handshake memory bank. NUM_LD independent load channels and one store channel
// share one flop array. Round-robin arbitration grants at most one access per
// cycle. Every committed store returns a done token on a separate
// valid/ready port.
//
// Optional feature (compile-time macro):
//   HS_MEM_OOR_CHECK_EN : when defined, a sticky oor_err flag records any load
//                         or store fire whose address is >= DEPTH. When not
//                         defined, oor_err is tied to 0.
//
// Parameters:
//   DATA_W   data width of every channel
//   ADDR_W   address width of every channel
//   DEPTH    number of stored words (1..2^ADDR_W, at most 256)
//   NUM_LD   number of load channels (1..8)
//   DONE_MAX maximum number of outstanding store-done tokens
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   ld_addr / ld_addr_valid / ld_addr_ready
//                             per-channel load request (packed, channel i at
//                             [i*ADDR_W +: ADDR_W]); ready is the grant
//   ld_data / ld_data_valid / ld_data_ready
//                             per-channel load response (packed like ld_addr)
//   st_addr / st_data / st_valid / st_ready
//                             store request; ready is the grant
//   st_done_valid / st_done_ready
//                             one token per committed store
//   oor_err                   sticky out-of-range flag
//
// Handshake semantics (all ports): a transfer happens at a rising clock edge
// where valid and ready are both 1. A producer keeps valid high and its
// payload stable until that transfer; ready may depend combinationally on the
// same-cycle valid.
// ============================================================================
module hs_mem_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int NUM_LD   = 2,
    parameter int DONE_MAX = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_LD*ADDR_W-1:0] ld_addr,
    input  logic [NUM_LD-1:0]        ld_addr_valid,
    output logic [NUM_LD-1:0]        ld_addr_ready,
    output logic [NUM_LD*DATA_W-1:0] ld_data,
    output logic [NUM_LD-1:0]        ld_data_valid,
    input  logic [NUM_LD-1:0]        ld_data_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic                     st_valid,
    output logic                     st_ready,
    output logic                     st_done_valid,
    input  logic                     st_done_ready,
    output logic                     oor_err
);

    // Requesters 0..NUM_LD-1 are the loads, requester NUM_LD is the store.
    localparam int NREQ   = NUM_LD + 1;
    localparam int RR_W   = $clog2(NREQ);
    localparam int PEND_W = $clog2(DONE_MAX + 1);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so "addr < DEPTH" is a true compare even when DEPTH is
    // exactly 2^ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(DONE_MAX);
    localparam logic [RR_W-1:0]   ST_REQ   = RR_W'(NUM_LD);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];     // storage, intentionally not reset
    logic [RR_W-1:0]   rr;              // round-robin search start
    logic [PEND_W-1:0] pend;            // outstanding done tokens
    logic              done_valid_q;    // registered (pend != 0)

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] elig;
    logic            gnt_any;
    logic [RR_W-1:0] gnt_idx;
    logic [RR_W-1:0] probe;
    logic            st_fire;

    // A load may be granted when its output slot is empty or is being
    // drained at this same edge, so a single channel sustains 1 load/cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            elig[i] = ld_addr_valid[i] && (!ld_data_valid[i] || ld_data_ready[i]);
        end
        elig[NUM_LD] = st_valid && (pend != PEND_MAX);
    end

    // First eligible requester at or after rr, wrapping at NREQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        probe   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(rr) + k >= NREQ) begin
                probe = RR_W'(int'(rr) + k - NREQ);
            end else begin
                probe = RR_W'(int'(rr) + k);
            end
            if (!gnt_any && elig[probe]) begin
                gnt_any = 1'b1;
                gnt_idx = probe;
            end
        end
    end

    // Grants are suppressed while reset is held so no ready is ever seen
    // asserted during reset.
    always_comb begin
        ld_addr_ready = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            ld_addr_ready[i] = gnt_any && !reset && (gnt_idx == RR_W'(i));
        end
        st_ready = gnt_any && !reset && (gnt_idx == ST_REQ);
    end

    assign st_fire = st_ready;

    // ------------------------------------------------------------------
    // Read path: only one load fires per cycle, so a single read port
    // addressed by the granted channel serves every channel.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_word;
    logic              st_in_range;

    always_comb begin
        rd_addr = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            if (gnt_idx == RR_W'(i)) begin
                rd_addr = ld_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);
    assign st_in_range = ({1'b0, st_addr} < DEPTH_C);

    // Out-of-range loads return zero rather than aliasing into the array.
    assign rd_word = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;

    // ------------------------------------------------------------------
    // Write path. A load granted in the cycle after a store already sees
    // the written word because the write lands at the store's edge.
    // Out-of-range stores are granted and tokened but never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (st_fire && st_in_range) begin
            mem[st_addr[IDX_W-1:0]] <= st_data;
        end
    end

    // ------------------------------------------------------------------
    // Done-token counter
    // ------------------------------------------------------------------
    logic              done_take;
    logic [PEND_W-1:0] pend_next;

    assign done_take = done_valid_q && st_done_ready;

    always_comb begin
        pend_next = pend;
        case ({st_fire, done_take})
            2'b10:   pend_next = pend + PEND_W'(1);
            2'b01:   pend_next = pend - PEND_W'(1);
            default: pend_next = pend;
        endcase
    end

    assign st_done_valid = done_valid_q;

    // ------------------------------------------------------------------
    // Control and load output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr            <= '0;
            pend          <= '0;
            done_valid_q  <= 1'b0;
            ld_data_valid <= '0;
            ld_data       <= '0;
        end else begin
            if (gnt_any) begin
                rr <= (gnt_idx == ST_REQ) ? '0 : gnt_idx + RR_W'(1);
            end

            // A fire refills the slot; otherwise a completed handshake
            // empties it. ld_data is only loaded on a fire, so it is held
            // stable while valid && !ready.
            for (int i = 0; i < NUM_LD; i++) begin
                if (ld_addr_ready[i]) begin
                    ld_data[i*DATA_W +: DATA_W] <= rd_word;
                    ld_data_valid[i]            <= 1'b1;
                end else if (ld_data_valid[i] && ld_data_ready[i]) begin
                    ld_data_valid[i] <= 1'b0;
                end
            end

            pend         <= pend_next;
            done_valid_q <= (pend_next != '0);
        end
    end

    // ------------------------------------------------------------------
    // Out-of-range reporting
    // ------------------------------------------------------------------
`ifdef HS_MEM_OOR_CHECK_EN
    logic oor_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oor_q <= 1'b0;
        end else if (((|ld_addr_ready) && !rd_in_range) || (st_fire && !st_in_range)) begin
            oor_q <= 1'b1;
        end
    end

    assign oor_err = oor_q;
`else
    assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_mem_bank.sv
// ============================================================================
// tb_hs_mem_bank
// ----------------------------------------------------------------------------
// Bench for hs_mem_bank (DEPTH=12 so out-of-range addresses are reachable).
// A behavioural model (plain arrays, counters and a round-robin pick over a
// list of requesters) predicts grants, token counts and load data. Expected
// load words and store tokens are queued when a grant is predicted; a
// separate monitor pops and compares them whenever the bank presents data.
// ============================================================================
module tb_hs_mem_bank;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 12;
    localparam int NUM_LD   = 2;
    localparam int DONE_MAX = 4;
    localparam int NREQ     = NUM_LD + 1;
`ifdef HS_MEM_OOR_CHECK_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_LD*ADDR_W-1:0] ld_addr = '0;
    logic [NUM_LD-1:0]        ld_addr_valid = '0;
    logic [NUM_LD-1:0]        ld_addr_ready;
    logic [NUM_LD*DATA_W-1:0] ld_data;
    logic [NUM_LD-1:0]        ld_data_valid;
    logic [NUM_LD-1:0]        ld_data_ready = '0;
    logic [ADDR_W-1:0]        st_addr = '0;
    logic [DATA_W-1:0]        st_data = '0;
    logic                     st_valid = 1'b0;
    logic                     st_ready;
    logic                     st_done_valid;
    logic                     st_done_ready = 1'b0;
    logic                     oor_err;

    always #5 clock = ~clock;

    hs_mem_bank #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .NUM_LD  (NUM_LD),
        .DONE_MAX(DONE_MAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ld_addr      (ld_addr),
        .ld_addr_valid(ld_addr_valid),
        .ld_addr_ready(ld_addr_ready),
        .ld_data      (ld_data),
        .ld_data_valid(ld_data_valid),
        .ld_data_ready(ld_data_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_done_valid(st_done_valid),
        .st_done_ready(st_done_ready),
        .oor_err      (oor_err)
    );

    // ------------------------------------------------------------------
    // Counters and checker
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard queues
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [NUM_LD-1:0] slot_m = '0;   // output slot holds unconsumed data
    int                pend_m = 0;
    int                rr_m   = 0;
    logic              oor_m  = 1'b0;
    int                last_g = -1;   // model grant of the latest cycle
    logic [DATA_W-1:0] exp_q [NUM_LD][$];
    logic [ADDR_W-1:0] done_q[$];
    int                dut_log[$];    // requester granted by the DUT, per cycle

    // Staged stimulus, applied to the DUT at the next falling edge.
    logic                     s_rst = 1'b1;
    logic [NUM_LD-1:0]        s_lv  = '0;
    logic [NUM_LD*ADDR_W-1:0] s_la  = '0;
    logic [NUM_LD-1:0]        s_lr  = '0;
    logic                     s_sv  = 1'b0;
    logic [ADDR_W-1:0]        s_sa  = '0;
    logic [DATA_W-1:0]        s_sd  = '0;
    logic                     s_sdr = 1'b0;

    // Predict this cycle's outcome from the current inputs, check the DUT's
    // visible state, then advance the model past the coming rising edge.
    task automatic model_step();
        int g;
        int r;
        logic [ADDR_W-1:0] a;
        logic [NUM_LD-1:0] exp_lr;
        logic take;
        last_g = -1;
        if (reset) begin
            chk("rst_ld_addr_ready", 64'(ld_addr_ready), 64'(0));
            chk("rst_st_ready", 64'(st_ready), 64'(0));
            chk("rst_ld_data_valid", 64'(ld_data_valid), 64'(0));
            chk("rst_st_done_valid", 64'(st_done_valid), 64'(0));
            chk("rst_ld_data", 64'(ld_data), 64'(0));
            chk("rst_oor_err", 64'(oor_err), 64'(0));
            slot_m = '0;
            pend_m = 0;
            rr_m   = 0;
            oor_m  = 1'b0;
            for (int i = 0; i < NUM_LD; i++) exp_q[i].delete();
            done_q.delete();
            return;
        end
        chk("ld_data_valid", 64'(ld_data_valid), 64'(slot_m));
        chk("st_done_valid", 64'(st_done_valid), 64'(pend_m != 0));
        chk("oor_err", 64'(oor_err), 64'(OOR_EN && oor_m));

        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            r = (rr_m + k) % NREQ;
            if (g < 0) begin
                if (r < NUM_LD) begin
                    if (ld_addr_valid[r] && (!slot_m[r] || ld_data_ready[r])) g = r;
                end else if (st_valid && pend_m < DONE_MAX) begin
                    g = r;
                end
            end
        end
        exp_lr = '0;
        if (g >= 0 && g < NUM_LD) exp_lr[g] = 1'b1;
        chk("ld_addr_ready", 64'(ld_addr_ready), 64'(exp_lr));
        chk("st_ready", 64'(st_ready), 64'(g == NUM_LD));

        take = (pend_m != 0) && st_done_ready;
        for (int i = 0; i < NUM_LD; i++) begin
            if (slot_m[i] && ld_data_ready[i]) slot_m[i] = 1'b0;
        end
        if (g >= 0 && g < NUM_LD) begin
            a = ld_addr[g*ADDR_W +: ADDR_W];
            exp_q[g].push_back((a < DEPTH) ? mem_m[a] : '0);
            if (a >= DEPTH) oor_m = 1'b1;
            slot_m[g] = 1'b1;
        end else if (g == NUM_LD) begin
            if (st_addr < DEPTH) mem_m[st_addr] = st_data;
            else oor_m = 1'b1;
            pend_m++;
            done_q.push_back(st_addr);
        end
        if (take) pend_m--;
        if (g >= 0) rr_m = (g + 1) % NREQ;
        last_g = g;
    endtask

    // One clock cycle: drive staged inputs on the falling edge, then check.
    task automatic cyc();
        int dg;
        @(negedge clock);
        reset         = s_rst;
        ld_addr_valid = s_lv;
        ld_addr       = s_la;
        ld_data_ready = s_lr;
        st_valid      = s_sv;
        st_addr       = s_sa;
        st_data       = s_sd;
        st_done_ready = s_sdr;
        #1;
        dg = -1;
        if (st_ready) dg = NUM_LD;
        for (int i = 0; i < NUM_LD; i++) if (ld_addr_ready[i]) dg = i;
        dut_log.push_back(dg);
        model_step();
    endtask

    task automatic set_idle();
        s_rst = 1'b0;
        s_lv  = '0;
        s_lr  = '1;
        s_sv  = 1'b0;
        s_sdr = 1'b1;
    endtask

    task automatic store_hold(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic acc;
        acc  = 1'b0;
        s_sv = 1'b1;
        s_sa = a;
        s_sd = d;
        for (int t = 0; t < 40 && !acc; t++) begin
            cyc();
            if (last_g == NUM_LD) acc = 1'b1;
        end
        s_sv = 1'b0;
        chk("store_accept_in_time", 64'(acc), 64'(1));
    endtask

    task automatic load_hold(input int ch, input logic [ADDR_W-1:0] a);
        logic acc;
        acc = 1'b0;
        s_lv[ch] = 1'b1;
        s_la[ch*ADDR_W +: ADDR_W] = a;
        for (int t = 0; t < 40 && !acc; t++) begin
            cyc();
            if (last_g == ch) acc = 1'b1;
        end
        s_lv[ch] = 1'b0;
        chk("load_accept_in_time", 64'(acc), 64'(1));
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare presented data with the expected queues
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                for (int i = 0; i < NUM_LD; i++) begin
                    if (ld_data_valid[i]) begin
                        chk("ld_expected_pending", 64'(exp_q[i].size() != 0), 64'(1));
                        if (exp_q[i].size() != 0) begin
                            chk($sformatf("ld_data_ch%0d", i),
                                64'(ld_data[i*DATA_W +: DATA_W]), 64'(exp_q[i][0]));
                            if (ld_data_ready[i]) void'(exp_q[i].pop_front());
                        end
                    end
                end
                if (st_done_valid && st_done_ready) begin
                    chk("done_token_expected", 64'(done_q.size() != 0), 64'(1));
                    if (done_q.size() != 0) void'(done_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int cnt;
        int cnt2;
        int order[6];
        order = '{0, 1, 2, 0, 1, 2};

        // Reset with requests pending: readies must stay low.
        s_rst = 1'b1; s_lv = '1; s_sv = 1'b1; s_lr = '1;
        cyc();
        cyc();
        set_idle();
        cyc();

        // Initialise every address (12..15 exercise out-of-range stores).
        for (int a = 0; a < 16; a++) store_hold(ADDR_W'(a), $urandom());
        set_idle();
        cyc();

        // Store then load the same address on the next cycle.
        store_hold(4'd3, 32'hDEADBEEF);
        s_la[3:0] = 4'd3; s_lv = 2'b01;
        cyc();
        chk("raw_load_grant", 64'(ld_addr_ready), 64'(2'b01));
        chk("raw_done_valid", 64'(st_done_valid), 64'(1));
        s_lv = '0;
        cyc();
        chk("raw_load_data", 64'(ld_data[31:0]), 64'(32'hDEADBEEF));

        // Reset with two tokens pending and slot 1 full; memory must survive.
        set_idle();
        repeat (3) cyc();
        s_sdr = 1'b0; s_lr = '0;
        store_hold(4'd1, 32'h1111_0001);
        store_hold(4'd2, 32'h2222_0002);
        load_hold(1, 4'd1);
        cyc();
        chk("pre_reset_done_valid", 64'(st_done_valid), 64'(1));
        chk("pre_reset_slot1", 64'(ld_data_valid[1]), 64'(1));
        s_rst = 1'b1; s_lv = '1; s_sv = 1'b1;
        cyc();
        set_idle();
        cyc();

        // Grant order with all three requesters busy, rr starting at 0.
        dut_log.delete();
        s_lv = 2'b11; s_la = {4'd2, 4'd1}; s_sv = 1'b1; s_sa = 4'd7; s_sd = 32'h7777_0007;
        repeat (6) cyc();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("grant_order_%0d", i), 64'(dut_log[i]), 64'(order[i]));
        end
        set_idle();
        cyc();
        chk("preserved_word_ch0", 64'(ld_data[31:0]), 64'(32'h1111_0001));
        chk("preserved_word_ch1", 64'(ld_data[63:32]), 64'(32'h2222_0002));
        repeat (3) cyc();

        // Token back-pressure: only DONE_MAX stores without consumption.
        s_sdr = 1'b0; s_sv = 1'b1; cnt = 0;
        repeat (6) begin
            s_sa = ADDR_W'($urandom_range(0, DEPTH - 1));
            s_sd = $urandom();
            cyc();
            if (st_ready) cnt++;
        end
        chk("done_max_accepts", 64'(cnt), 64'(DONE_MAX));
        chk("st_ready_when_full", 64'(st_ready), 64'(0));
        cnt2 = 0;
        s_sdr = 1'b1;
        cyc();
        if (st_ready) cnt2++;
        s_sdr = 1'b0;
        repeat (3) begin
            cyc();
            if (st_ready) cnt2++;
        end
        chk("one_more_store", 64'(cnt2), 64'(1));
        set_idle();
        repeat (7) cyc();

        // Load back-pressure on channel 0, then drain with a same-cycle regrant.
        s_lr = 2'b10; s_lv = 2'b01; s_la[3:0] = 4'd4;
        cyc();
        repeat (5) begin
            cyc();
            chk("bp_no_grant_ch0", 64'(ld_addr_ready[0]), 64'(0));
            chk("bp_data_stable", 64'(ld_data[31:0]), 64'(mem_m[4]));
        end
        s_lr = 2'b11;
        cyc();
        chk("bp_drain_regrant", 64'(ld_addr_ready[0]), 64'(1));
        set_idle();
        repeat (2) cyc();

        // Out-of-range load and store.
        load_hold(0, 4'd14);
        cyc();
        chk("oor_load_zero", 64'(ld_data[31:0]), 64'(0));
        chk("oor_flag_after_load", 64'(oor_err), 64'(OOR_EN));
        store_hold(4'd13, 32'hBAD0_0013);
        cyc();
        chk("oor_store_token", 64'(st_done_valid), 64'(1));
        chk("oor_flag_sticky", 64'(oor_err), 64'(OOR_EN));
        load_hold(1, 4'd1);
        load_hold(0, 4'd13);
        set_idle();
        repeat (2) cyc();

        // Randomised traffic; requests are held until granted.
        for (int n = 0; n < 1500; n++) begin
            for (int ch = 0; ch < NUM_LD; ch++) begin
                if (!s_lv[ch] || last_g == ch) begin
                    s_lv[ch] = ($urandom_range(0, 99) < 60);
                    s_la[ch*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 15));
                end
                s_lr[ch] = ($urandom_range(0, 99) < 70);
            end
            if (!s_sv || last_g == NUM_LD) begin
                s_sv = ($urandom_range(0, 99) < 40);
                s_sa = ADDR_W'($urandom_range(0, 15));
                s_sd = $urandom();
            end
            s_sdr = ($urandom_range(0, 99) < 50);
            s_rst = ($urandom_range(0, 399) == 0);
            cyc();
        end

        // Drain and confirm nothing expected is left over.
        set_idle();
        repeat (10) cyc();
        chk("drain_q_ch0", 64'(exp_q[0].size()), 64'(0));
        chk("drain_q_ch1", 64'(exp_q[1].size()), 64'(0));
        chk("drain_done_q", 64'(done_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
